ps2_frame_decoder: RTL and testbench

//   Receives PS/2 Set 2 device-to-host frames from the keyboard pins and emits
//   one 8-bit scan code per valid frame as a single-cycle pulse. Sits directly

---
 rtl/ps2_frame_decoder.sv | 163 ++++++++++++++++
 tb/tb_ps2_frame_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_decoder.sv
// PS/2 device-to-host frame receiver.
// Synchronises and deglitches the raw PS/2 pins, decodes 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop) and emits each good byte
// as a one-cycle pulse. Stalled frames are aborted after TIMEOUT_CYCLES.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset (released synchronously inside)
//   ps2_clk      raw PS/2 clock pin, idle high
//   ps2_data     raw PS/2 data pin, idle high
//   scan_code    last correctly received byte, held between frames
//   scan_valid   one-cycle pulse, scan_code updated this cycle
//   frame_error  one-cycle pulse, frame rejected (start/parity/stop/timeout)
//   busy         high while a frame is in progress
module ps2_frame_decoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Reset: asserts asynchronously, releases two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Pin synchronisers, reset to the idle-high level.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Clock deglitch: the filtered level only follows after FILTER_LEN
  // consecutive samples that disagree with it.
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_q;
  logic             filt_del_q;
  logic             fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_q <= '0;
      filt_q     <= 1'b1;
      filt_del_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_cnt_q <= '0;
        filt_q     <= ~filt_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
      filt_del_q <= filt_q;
      fall_q     <= filt_del_q & ~filt_q;
    end
  end

  // Frame FSM with stall timeout.
  state_e         state_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [ToW-1:0] to_cnt_q;
  logic [7:0]     scan_code_q;
  logic           scan_valid_q;
  logic           frame_error_q;
  logic           timeout;

  assign timeout = (state_q != StIdle) && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      scan_code_q   <= 8'h00;
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      scan_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      if (timeout) begin
        // Takes priority over a coincident fall; the partial byte is dropped.
        state_q       <= StIdle;
        to_cnt_q      <= '0;
        frame_error_q <= 1'b1;
      end else begin
        if (state_q == StIdle || fall_q) to_cnt_q <= '0;
        else                             to_cnt_q <= to_cnt_q + ToW'(1);
        if (fall_q) begin
          unique case (state_q)
            StIdle: begin
              if (!data_s) begin
                state_q   <= StData;
                bit_cnt_q <= 3'd0;
              end
            end
            StData: begin
              shift_q   <= {data_s, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= StParity;
            end
            StParity: begin
              parity_q <= data_s;
              state_q  <= StStop;
            end
            StStop: begin
              state_q <= StIdle;
              if (data_s && (^{shift_q, parity_q})) begin
                scan_code_q  <= shift_q;
                scan_valid_q <= 1'b1;
              end else begin
                frame_error_q <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign scan_code   = scan_code_q;
  assign scan_valid  = scan_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ps2_frame_decoder.sv
// Directed bench for ps2_frame_decoder with a shortened timeout and a PS/2
// clock half-period of H system clocks.
module tb_ps2_frame_decoder;

  localparam int unsigned H  = 20;
  localparam int unsigned TO = 400;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_error;
  logic       busy;

  always #5 clk = ~clk;

  ps2_frame_decoder #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int fall_cyc   = 0;

  // Pulse monitor
  int         valid_cnt = 0;
  int         err_cnt   = 0;
  int         both_cnt  = 0;
  int         valid_cyc = 0;
  logic [7:0] last_code = 8'h00;
  logic [7:0] prev_code = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (scan_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
      prev_code <= last_code;
      last_code <= scan_code;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
    if (scan_valid && frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(H);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(H);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int from, input int upto);
    for (int i = from; i <= upto; i++) send_bit(f[i]);
  endtask

  task automatic finish_frame();
    wait_cyc(H + 20);
    ps2_data = 1'b1;
  endtask

  // {stop, parity, data, start}; parity is odd unless flipped
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip,
                                           input logic stop);
    return {stop, (~^d) ^ flip, d, 1'b0};
  endfunction

  int          v0;
  int          e0;
  logic [10:0] f;

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(4);
    check("rst_code", {24'h0, scan_code}, 32'h00);
    check("rst_valid", {31'h0, scan_valid}, 32'h0);
    check("rst_err", {31'h0, frame_error}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    wait_cyc(5);

    // Single good frame 0x1C
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    finish_frame();
    check("t1_valid_n", valid_cnt - v0, 1);
    check("t1_err_n", err_cnt - e0, 0);
    check("t1_code", {24'h0, scan_code}, 32'h1C);
    check("t1_latency", valid_cyc - fall_cyc, 12);
    check("t1_busy", {31'h0, busy}, 32'h0);

    // Back-to-back F0, 1C
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 10);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10);
    finish_frame();
    check("t2_valid_n", valid_cnt - v0, 2);
    check("t2_err_n", err_cnt - e0, 0);
    check("t2_first", {24'h0, prev_code}, 32'hF0);
    check("t2_second", {24'h0, last_code}, 32'h1C);

    // Bad parity, then bad stop
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 0, 10);
    finish_frame();
    check("t3p_err_n", err_cnt - e0, 1);
    check("t3p_valid_n", valid_cnt - v0, 0);
    check("t3p_code", {24'h0, scan_code}, 32'h1C);
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 0, 10);
    finish_frame();
    check("t3s_err_n", err_cnt - e0, 1);
    check("t3s_valid_n", valid_cnt - v0, 0);
    check("t3s_code", {24'h0, scan_code}, 32'h1C);

    // Stall after five bits, then recovery with 0x12
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h12, 1'b0, 1'b1), 0, 4);
    ps2_data = 1'b1;
    wait_cyc(20);
    check("t4_busy_mid", {31'h0, busy}, 32'h1);
    check("t4_no_err_early", err_cnt - e0, 0);
    wait_cyc(TO + 50);
    check("t4_err_n", err_cnt - e0, 1);
    check("t4_busy_after", {31'h0, busy}, 32'h0);
    check("t4_valid_n", valid_cnt - v0, 0);
    v0 = valid_cnt;
    send_bits(mk_frame(8'h12, 1'b0, 1'b1), 0, 10);
    finish_frame();
    check("t4_rec_valid_n", valid_cnt - v0, 1);
    check("t4_rec_code", {24'h0, scan_code}, 32'h12);

    // Short clock glitches: idle and mid-frame
    v0 = valid_cnt; e0 = err_cnt;
    ps2_clk = 1'b0;
    wait_cyc(6);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("t5_idle_busy", {31'h0, busy}, 32'h0);
    check("t5_idle_err", err_cnt - e0, 0);
    f = mk_frame(8'h5A, 1'b0, 1'b1);
    send_bits(f, 0, 3);
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(6);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check("t5_mid_busy", {31'h0, busy}, 32'h1);
    send_bits(f, 4, 10);
    finish_frame();
    check("t5_valid_n", valid_cnt - v0, 1);
    check("t5_err_n", err_cnt - e0, 0);
    check("t5_code", {24'h0, scan_code}, 32'h5A);

    // Reset mid-frame, then 0x29
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 0, 4);
    wait_cyc(3);
    reset_n = 1'b0;
    #1;
    check("t6_code", {24'h0, scan_code}, 32'h00);
    check("t6_valid", {31'h0, scan_valid}, 32'h0);
    check("t6_err", {31'h0, frame_error}, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    wait_cyc(3);
    reset_n  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 0, 10);
    finish_frame();
    check("t6_valid_n", valid_cnt - v0, 1);
    check("t6_err_n", err_cnt - e0, 0);
    check("t6_rec_code", {24'h0, scan_code}, 32'h29);

    check("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
